// File: rtl/erm_core_param.sv
// erm_core_param: multi-cycle register CPU with a request/acknowledge memory
// port, a registered OUT port and one level-sensitive interrupt.
// Instruction: [DW-1:DW-4] opcode, [DW-5:DW-7] rd, [DW-8:DW-10] rs,
// [DW-11:0] immediate (sign-extended).
module erm_core_param #(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   NREG     = 8,
    parameter logic [DW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] IVEC     = 'h0010
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          io_we,
    output logic [DW-1:0] io_data,
    input  logic          irq,
    output logic          intack,
    output logic          halted
);

    localparam int unsigned OPW  = 4;
    localparam int unsigned RFW  = 3;
    localparam int unsigned RFD  = 8;
    localparam int unsigned IMMW = DW - OPW - 2 * RFW;

    // One bit per register-field value: set when that register exists.
    localparam logic [RFD-1:0] REG_OK = RFD'((1 << NREG) - 1);
    // Register that receives the return address when an interrupt is taken.
    localparam logic [RFW-1:0] LINK   = RFW'(NREG - 1);

    localparam logic [OPW-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW-1:0] OP_MOVI = 4'h1;
    localparam logic [OPW-1:0] OP_ADD  = 4'h2;
    localparam logic [OPW-1:0] OP_SUB  = 4'h3;
    localparam logic [OPW-1:0] OP_AND  = 4'h4;
    localparam logic [OPW-1:0] OP_OR   = 4'h5;
    localparam logic [OPW-1:0] OP_XOR  = 4'h6;
    localparam logic [OPW-1:0] OP_LD   = 4'h7;
    localparam logic [OPW-1:0] OP_ST   = 4'h8;
    localparam logic [OPW-1:0] OP_JMP  = 4'h9;
    localparam logic [OPW-1:0] OP_JZ   = 4'hA;
    localparam logic [OPW-1:0] OP_OUT  = 4'hB;
    localparam logic [OPW-1:0] OP_HLT  = 4'hC;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t          state;
    logic [DW-1:0]   pc;
    logic [DW-1:0]   ir;
    logic [DW-1:0]   regs [RFD];
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic            flag_z;
    logic            flag_c;
    // Set in the intack cycle; the next cycle saves pc and fetches from IVEC.
    logic            irq_pend;

    logic [OPW-1:0]  opcode;
    logic [RFW-1:0]  rd_f;
    logic [RFW-1:0]  rs_f;
    logic [DW-1:0]   imm_x;
    logic            is_alu;
    logic [DW:0]     alu_wide;
    logic [DW-1:0]   exec_pc;

    assign opcode = ir[DW-1 -: OPW];
    assign rd_f   = ir[DW-OPW-1 -: RFW];
    assign rs_f   = ir[DW-OPW-RFW-1 -: RFW];
    assign imm_x  = DW'($signed(ir[IMMW-1:0]));
    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_XOR);

    // ALU: one extra bit carries ADD carry-out / SUB borrow.
    always_comb begin
        alu_wide = '0;
        case (opcode)
            OP_ADD:  alu_wide = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_wide = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_wide = {1'b0, op_a & op_b};
            OP_OR:   alu_wide = {1'b0, op_a | op_b};
            OP_XOR:  alu_wide = {1'b0, op_a ^ op_b};
            default: alu_wide = '0;
        endcase
    end

    // Program counter at the end of EXEC (pc already points past the instruction).
    always_comb begin
        exec_pc = pc;
        if (opcode == OP_JMP) begin
            exec_pc = op_b;
        end else if ((opcode == OP_JZ) && flag_z) begin
            exec_pc = pc + imm_x;
        end
    end

    // Control FSM, datapath registers and all registered outputs.
    always_ff @(posedge clk) begin
        io_we  <= 1'b0;
        intack <= 1'b0;
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            irq_pend  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            io_data   <= '0;
            halted    <= 1'b0;
            for (int i = 0; i < int'(RFD); i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (irq_pend) begin
                        // Second interrupt cycle: link, vector, start the fetch.
                        regs[LINK] <= pc;
                        pc         <= IVEC;
                        irq_pend   <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= IVEC;
                    end else if (!mem_req) begin
                        // Boundary cycle after reset: no request is out yet.
                        if (irq) begin
                            intack   <= 1'b1;
                            irq_pend <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= pc;
                        end
                    end else if (mem_ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc + DW'(1);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    op_a  <= REG_OK[rd_f] ? regs[rd_f] : '0;
                    op_b  <= REG_OK[rs_f] ? regs[rs_f] : '0;
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (opcode == OP_ST);
                        mem_addr  <= op_b;
                        mem_wdata <= op_a;
                        state     <= S_MEM;
                    end else if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        if (is_alu) begin
                            if (REG_OK[rd_f]) begin
                                regs[rd_f] <= alu_wide[DW-1:0];
                            end
                            flag_z <= (alu_wide[DW-1:0] == '0);
                            flag_c <= alu_wide[DW];
                        end else if (opcode == OP_MOVI) begin
                            if (REG_OK[rd_f]) begin
                                regs[rd_f] <= imm_x;
                            end
                        end else if (opcode == OP_OUT) begin
                            io_we   <= 1'b1;
                            io_data <= op_a;
                        end
                        pc    <= exec_pc;
                        state <= S_FETCH;
                        // Instruction boundary: take the interrupt or fetch.
                        if (irq) begin
                            intack   <= 1'b1;
                            irq_pend <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= exec_pc;
                        end
                    end
                end

                S_MEM: begin
                    if (mem_ack) begin
                        if ((opcode == OP_LD) && REG_OK[rd_f]) begin
                            regs[rd_f] <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_FETCH;
                        // Instruction boundary: take the interrupt or fetch.
                        if (irq) begin
                            intack   <= 1'b1;
                            irq_pend <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end
                    end
                end

                S_HALT: begin
                    if (irq) begin
                        intack   <= 1'b1;
                        irq_pend <= 1'b1;
                        halted   <= 1'b0;
                        state    <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/erm_core_param.md
ERM_CORE_PARAM -- requirements
Module: erm_core_param

Interface
REQ-001 Parameter DW, default 16, meaning data/address/instruction width in bits; legal range 16..32.
REQ-002 Parameter NREG, default 8, meaning register file depth; fixed register field width 3 bits, so legal values 2..8; fields addressing >= NREG read 0 and do not write.
REQ-003 Parameter RESET_PC, default 0, meaning PC value after reset.
REQ-004 Parameter IVEC, default 'h0010, meaning interrupt vector address.
REQ-005 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port mem_req  output  1  memory access request, held until acknowledged.
REQ-008 Port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 Port mem_addr  output  DW  access address; valid while mem_req=1.
REQ-010 Port mem_wdata  output  DW  write data; valid while mem_req=1 and mem_we=1.
REQ-011 Port mem_rdata  input  DW  read data; sampled in the cycle mem_ack=1.
REQ-012 Port mem_ack  input  1  completes the pending request in the cycle it is high together with mem_req.
REQ-013 Port io_we  output  1  one-cycle pulse on OUT.
REQ-014 Port io_data  output  DW  OUT data; held until next OUT.
REQ-015 Port irq  input  1  level-sensitive interrupt request.
REQ-016 Port intack  output  1  one-cycle pulse when an interrupt is taken.
REQ-017 Port halted  output  1  high while in HALT state.

Function
REQ-018 Instruction word DW bits; opcode = [DW-1:DW-4], rd = [DW-5:DW-7], rs = [DW-8:DW-10], imm = [DW-11:0] sign-extended to DW.
REQ-019 Opcodes: 0 NOP; 1 MOVI rd<=imm; 2 ADD rd<=rd+rs; 3 SUB rd<=rd-rs; 4 AND; 5 OR; 6 XOR; 7 LD rd<=mem[rs]; 8 ST mem[rs]<=rd; 9 JMP pc<=rs; A JZ if Z then pc<=pc+imm; B OUT io_data<=rd; C HLT; D..F execute as NOP.
REQ-020 Flags Z and C updated only by opcodes 2..6: Z = (result==0); C = carry-out for ADD, borrow for SUB, 0 for logic ops.
REQ-021 All arithmetic modulo 2^DW; PC increments by 1 modulo 2^DW (wrap from all-ones to 0).
REQ-022 States: FETCH, DECODE, EXEC, MEM, HALT.
REQ-023 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch IR, pc<=pc+1, go DECODE; otherwise stay (wait states unbounded).
REQ-024 DECODE: one cycle, read rd/rs operands; go EXEC.
REQ-025 EXEC: ALU/MOVI/JMP/JZ/OUT/NOP complete and go FETCH; LD/ST go MEM; HLT goes HALT.
REQ-026 JZ target is pc+imm where pc is already incremented.
REQ-027 MEM: mem_req=1, mem_addr=rs value, mem_we=1 for ST; on mem_ack LD writes rd, go FETCH.
REQ-028 Zero-wait latency: ALU-class instruction 3 cycles, LD/ST 4 cycles; each wait cycle adds 1.
REQ-029 mem_addr/mem_we/mem_wdata shall remain stable while mem_req=1 and mem_ack=0.
REQ-030 Interrupt checked only on entry to FETCH (instruction boundary) and in HALT: if irq=1, R[NREG-1]<=pc, pc<=IVEC, intack=1 for that cycle, no fetch issued that cycle; then FETCH from IVEC.
REQ-031 irq during FETCH wait, DECODE, EXEC or MEM is not taken until the next boundary.
REQ-032 HALT: mem_req=0, halted=1; leave only via irq (REQ-030) or rst.
REQ-033 mem_ack with mem_req=0 shall be ignored.

Reset
REQ-034 While rst=1 at a rising edge: state<=FETCH, pc<=RESET_PC, all registers<=0, Z=C=0, io_data<=0; mem_req, io_we, intack, halted = 0 in the cycle after.
REQ-035 rst mid-access aborts the request; mem_req drops the following cycle; no register or flag write occurs.

Verification
REQ-036 MOVI R0,#1 then ADD R0,R0, zero-wait memory -> R0=2, Z=0, C=0, completion 3 cycles each.
REQ-037 DW=16: MOVI R1,#-1; MOVI R2,#1; ADD R1,R2 -> R1=0, Z=1, C=1; following JZ #+2 skips two words.
REQ-038 ST R3->[R4=0x20] with 3 wait cycles -> mem_req high 4 cycles, address/data stable, mem_we=1.
REQ-039 HLT with irq=0 for 10 cycles -> halted=1, mem_req=0; raise irq -> intack pulse, R7=HLT addr+1, next fetch address 0x0010.
REQ-040 DW=32 build: MOVI R5,#-3 -> R5=0xFFFFFFFD; OUT R5 -> io_we pulse, io_data=0xFFFFFFFD.
REQ-041 rst asserted during a LD wait state -> pc=RESET_PC, rd unchanged-to-zero, first post-reset fetch at RESET_PC.
